bcd_clock_counter: RTL and testbench
====================================

BCD_CLOCK_COUNTER -- requirements
Module: bcd_clock_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000000, giving clk cycles per one-second tick (legal range 2..2^24).
REQ-002 The block SHALL have parameter MODE_12H, default 0: 0 = 24-hour count, 1 = 12-hour count with AM/PM flag.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; low freezes prescaler and time.
REQ-006 load  input  1  single-cycle request to load load_hh/load_mm/load_ss/load_pm.
REQ-007 load_hh, load_mm, load_ss  input  8 each  packed two-digit BCD load values, tens in [7:4].
REQ-008 load_pm  input  1  PM flag to load; ignored when MODE_12H=0.
REQ-009 hh, mm, ss  output  8 each  current time, packed two-digit BCD, registered.
REQ-010 pm  output  1  PM flag; constant 0 when MODE_12H=0.
REQ-011 sec_tick  output  1  one-cycle pulse in the cycle time advances.
REQ-012 day_wrap  output  1  one-cycle pulse when time wraps to start of day.
REQ-013 load_err  output  1  one-cycle pulse when a load request is rejected.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 while en=1; on reaching TICK_DIV-1 it SHALL return to 0 and the time SHALL advance by one second, visible on ss/mm/hh the following cycle together with sec_tick=1.
REQ-015 Seconds SHALL count 00..59 in BCD (units 0..9, tens 0..5); 59->00 SHALL carry into minutes in the same cycle.
REQ-016 Minutes SHALL count 00..59 identically; 59->00 with seconds carry SHALL carry into hours in the same cycle.
REQ-017 MODE_12H=0: hours SHALL count 00..23; 23:59:59->00:00:00 SHALL pulse day_wrap.
REQ-018 MODE_12H=1: hours SHALL sequence 12,01,02..11,12; 11:59:59->12:00:00 SHALL toggle pm; day_wrap SHALL pulse on the PM->AM toggle.
REQ-019 No output digit SHALL ever hold a non-BCD value (A..F) or an out-of-range time.
REQ-020 load SHALL be accepted when every digit is 0..9, load_ss<=0x59, load_mm<=0x59, and load_hh<=0x23 (24h) or 0x01..0x12 (12h); else the load SHALL be ignored and load_err SHALL pulse the next cycle.
REQ-021 An accepted load SHALL update hh/mm/ss/pm the next cycle and clear the prescaler to 0.
REQ-022 load SHALL operate regardless of en.
REQ-023 load coincident with a prescaler terminal count SHALL win; that tick SHALL be dropped and sec_tick SHALL stay 0.
REQ-024 en=0 coincident with terminal count SHALL hold prescaler and time; no tick.
REQ-025 sec_tick, day_wrap and load_err SHALL each be high for exactly one cycle per event.

Reset
REQ-026 rst=1 at a rising clk edge SHALL force prescaler=0, ss=0x00, mm=0x00, sec_tick=day_wrap=load_err=0, pm=0, hh=0x00 (24h) or 0x12 (12h).
REQ-027 rst SHALL override load and en in the same cycle, including mid-count and mid-carry.

Configuration
REQ-028 With BCD_CLOCK_ALARM_EN defined, the block SHALL add inputs alarm_arm (1), alarm_hh (8), alarm_mm (8), alarm_pm (1) and output alarm_hit (1).
REQ-029 With BCD_CLOCK_ALARM_EN defined, alarm_hit SHALL pulse for one cycle, coincident with sec_tick, when alarm_arm=1 and time advances to alarm_hh:alarm_mm:00 (pm matching in 12h); a load to that time SHALL NOT fire it; reset value 0.
REQ-030 Without BCD_CLOCK_ALARM_EN, those ports and all alarm logic SHALL be absent.

Verification (TICK_DIV=4 unless stated)
REQ-031 rst high 2 cycles, en=1 for 40 cycles -> reset values per REQ-026, then sec_tick every 4th cycle, ss reaches 0x10 after 10 ticks with units never exceeding 9.
REQ-032 MODE_12H=0, load 23:59:58, en=1 -> after 2 ticks hh:mm:ss=00:00:00, day_wrap one pulse coincident with the second sec_tick.
REQ-033 MODE_12H=1, load 11:59:59 pm=0 -> next tick 12:00:00 pm=1; load 11:59:59 pm=1 -> next tick 12:00:00 pm=0 with day_wrap.
REQ-034 Load ss=0x5A, then hh=0x24 (24h), then hh=0x00 (12h) -> each ignored, time unchanged, load_err one pulse each.
REQ-035 Load asserted on the prescaler terminal-count cycle -> loaded value appears, no sec_tick, next tick exactly 4 cycles later; rst asserted mid-count -> REQ-026 values next cycle.
REQ-036 BCD_CLOCK_ALARM_EN, alarm 00:01 armed, load 00:00:58 -> alarm_hit single pulse at 00:01:00; disarmed repeat -> no pulse.

Source files
------------

// File: rtl/bcd_clock_counter.sv
// bcd_clock_counter
//   Time-of-day counter in packed two-digit BCD. A prescaler divides clk by
//   TICK_DIV to produce one-second ticks; seconds/minutes/hours ripple in the
//   same cycle. Runs in 24-hour mode or 12-hour mode with an AM/PM flag.
//
// Parameters
//   TICK_DIV  clk cycles per second tick (2..2^24)
//   MODE_12H  0 = 24-hour (hh 00..23), 1 = 12-hour (hh 12,01..11, pm flag)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   en                           count enable (freezes prescaler and time)
//   load, load_hh/mm/ss, load_pm load request and BCD values
//   hh, mm, ss, pm               current time (registered)
//   sec_tick, day_wrap, load_err one-cycle event pulses
//
// Build option
//   BCD_CLOCK_ALARM_EN  adds alarm_arm/alarm_hh/alarm_mm/alarm_pm inputs and
//                       the alarm_hit pulse output.
module bcd_clock_counter #(
  parameter int TICK_DIV = 1000000,
  parameter bit MODE_12H = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
`ifdef BCD_CLOCK_ALARM_EN
  input  logic       alarm_arm,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_pm,
  output logic       alarm_hit,
`endif
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam logic [23:0] CNT_TC = 24'(TICK_DIV - 1);
  localparam logic [7:0]  HH_RST = MODE_12H ? 8'h12 : 8'h00;

  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic        pm_q, pm_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;
  logic        ss_ok, mm_ok, hh_ok, load_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    pm_d   = pm_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;

    ss_ok = (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9);
    mm_ok = (load_mm[7:4] <= 4'd5) && (load_mm[3:0] <= 4'd9);
    if (MODE_12H)
      hh_ok = ((load_hh[7:4] == 4'd0) && (load_hh[3:0] != 4'd0) && (load_hh[3:0] <= 4'd9)) ||
              (load_hh == 8'h10) || (load_hh == 8'h11) || (load_hh == 8'h12);
    else
      hh_ok = ((load_hh[7:4] <= 4'd1) && (load_hh[3:0] <= 4'd9)) ||
              ((load_hh[7:4] == 4'd2) && (load_hh[3:0] <= 4'd3));
    load_ok = load && ss_ok && mm_ok && hh_ok;

    if (load_ok) begin
      // A valid load always wins over a coincident terminal count.
      hh_d  = load_hh;
      mm_d  = load_mm;
      ss_d  = load_ss;
      pm_d  = MODE_12H ? load_pm : 1'b0;
      cnt_d = '0;
    end else begin
      // A rejected load is ignored entirely; counting carries on.
      err_d = load;
      if (en) begin
        if (cnt_q == CNT_TC) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (ss_q == 8'h59) begin
            ss_d = 8'h00;
            if (mm_q == 8'h59) begin
              mm_d = 8'h00;
              if (MODE_12H) begin
                if (hh_q == 8'h12) begin
                  hh_d = 8'h01;
                end else if (hh_q == 8'h11) begin
                  // 11:59:59 -> 12:00:00 flips AM/PM; PM->AM is midnight.
                  hh_d   = 8'h12;
                  pm_d   = ~pm_q;
                  wrap_d = pm_q;
                end else begin
                  hh_d = bcd_inc(hh_q);
                end
              end else begin
                if (hh_q == 8'h23) begin
                  hh_d   = 8'h00;
                  wrap_d = 1'b1;
                end else begin
                  hh_d = bcd_inc(hh_q);
                end
              end
            end else begin
              mm_d = bcd_inc(mm_q);
            end
          end else begin
            ss_d = bcd_inc(ss_q);
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
    end
  end

`ifdef BCD_CLOCK_ALARM_EN
  logic alarm_q, alarm_d;

  // Only a counted tick can fire the alarm, never a load.
  always_comb begin
    alarm_d = tick_d && alarm_arm && (hh_d == alarm_hh) && (mm_d == alarm_mm) &&
              (ss_d == 8'h00) && (!MODE_12H || (pm_d == alarm_pm));
  end

  always_ff @(posedge clk) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= alarm_d;
  end

  assign alarm_hit = alarm_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hh_q   <= HH_RST;
      mm_q   <= 8'h00;
      ss_q   <= 8'h00;
      pm_q   <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hh_q   <= hh_d;
      mm_q   <= mm_d;
      ss_q   <= ss_d;
      pm_q   <= pm_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign hh       = hh_q;
  assign mm       = mm_q;
  assign ss       = ss_q;
  assign pm       = pm_q;
  assign sec_tick = tick_q;
  assign day_wrap = wrap_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Bench for bcd_clock_counter: a 24-hour and a 12-hour instance (TICK_DIV=4)
// share one stimulus stream. A seconds-of-day reference model for each runs
// alongside and is compared every cycle; directed vectors and sequences add
// explicit expectations for the corner cases.
module tb_bcd_clock_counter;
  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load, load_pm;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh_a, mm_a, ss_a, hh_b, mm_b, ss_b;
  logic       pm_a, tick_a, wrap_a, err_a, pm_b, tick_b, wrap_b, err_b;
`ifdef BCD_CLOCK_ALARM_EN
  logic       alarm_arm, alarm_pm, ahit_a, ahit_b;
  logic [7:0] alarm_hh, alarm_mm;
`endif

  bcd_clock_counter #(.TICK_DIV(TD), .MODE_12H(1'b0)) dut_24 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
`ifdef BCD_CLOCK_ALARM_EN
    .alarm_arm(alarm_arm), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_pm(alarm_pm), .alarm_hit(ahit_a),
`endif
    .hh(hh_a), .mm(mm_a), .ss(ss_a), .pm(pm_a),
    .sec_tick(tick_a), .day_wrap(wrap_a), .load_err(err_a));

  bcd_clock_counter #(.TICK_DIV(TD), .MODE_12H(1'b1)) dut_12 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
`ifdef BCD_CLOCK_ALARM_EN
    .alarm_arm(alarm_arm), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_pm(alarm_pm), .alarm_hit(ahit_b),
`endif
    .hh(hh_b), .mm(mm_b), .ss(ss_b), .pm(pm_b),
    .sec_tick(tick_b), .day_wrap(wrap_b), .load_err(err_b));

  int checks = 0;
  int failures = 0;

  // Reference model: time kept as seconds since midnight, index 0 = 24h, 1 = 12h.
  int m_sec[2];
  int m_pre[2];
  bit m_tick[2], m_wrap[2], m_err[2], m_ahit[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit dig_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] exp_hh(input int md);
    int h;
    h = m_sec[md] / 3600;
    if (md == 0) return bcd(h);
    return bcd((h % 12 == 0) ? 12 : h % 12);
  endfunction

  function automatic logic [7:0] exp_mm(input int md);
    return bcd((m_sec[md] / 60) % 60);
  endfunction

  function automatic logic [7:0] exp_ss(input int md);
    return bcd(m_sec[md] % 60);
  endfunction

  function automatic bit exp_pm(input int md);
    return (md == 1) && (m_sec[md] >= 12 * 3600);
  endfunction

  task automatic model_step(input int md);
    int h, mi, s;
    bit ok;
    m_tick[md] = 0; m_wrap[md] = 0; m_err[md] = 0; m_ahit[md] = 0;
    h = dec(load_hh); mi = dec(load_mm); s = dec(load_ss);
    ok = dig_ok(load_hh) && dig_ok(load_mm) && dig_ok(load_ss) && mi <= 59 && s <= 59 &&
         ((md == 0) ? (h <= 23) : (h >= 1 && h <= 12));
    if (rst) begin
      m_sec[md] = 0;
      m_pre[md] = 0;
    end else if (load && ok) begin
      if (md == 1) h = (h % 12) + (load_pm ? 12 : 0);
      m_sec[md] = h * 3600 + mi * 60 + s;
      m_pre[md] = 0;
    end else begin
      m_err[md] = load;
      if (en) begin
        if (m_pre[md] == TD - 1) begin
          m_pre[md]  = 0;
          m_tick[md] = 1;
          m_sec[md]  = (m_sec[md] + 1) % 86400;
          m_wrap[md] = (m_sec[md] == 0);
`ifdef BCD_CLOCK_ALARM_EN
          begin
            int ah;
            bit aok;
            ah = dec(alarm_hh);
            aok = dig_ok(alarm_hh) && dig_ok(alarm_mm) && dec(alarm_mm) <= 59 &&
                  ((md == 0) ? (ah <= 23) : (ah >= 1 && ah <= 12));
            if (md == 1) ah = (ah % 12) + (alarm_pm ? 12 : 0);
            m_ahit[md] = alarm_arm && aok && (m_sec[md] == ah * 3600 + dec(alarm_mm) * 60);
          end
`endif
        end else begin
          m_pre[md]++;
        end
      end
    end
  endtask

  task automatic check_models();
    chk("m24_hh", hh_a, exp_hh(0));
    chk("m24_mm", mm_a, exp_mm(0));
    chk("m24_ss", ss_a, exp_ss(0));
    chk("m24_pm", pm_a, exp_pm(0));
    chk("m24_tick", tick_a, m_tick[0]);
    chk("m24_wrap", wrap_a, m_wrap[0]);
    chk("m24_err", err_a, m_err[0]);
    chk("m12_hh", hh_b, exp_hh(1));
    chk("m12_mm", mm_b, exp_mm(1));
    chk("m12_ss", ss_b, exp_ss(1));
    chk("m12_pm", pm_b, exp_pm(1));
    chk("m12_tick", tick_b, m_tick[1]);
    chk("m12_wrap", wrap_b, m_wrap[1]);
    chk("m12_err", err_b, m_err[1]);
`ifdef BCD_CLOCK_ALARM_EN
    chk("m24_alarm", ahit_a, m_ahit[0]);
    chk("m12_alarm", ahit_b, m_ahit[1]);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_models();
  endtask

  task automatic drive(input bit r, input bit e, input bit l, input logic [7:0] h,
                       input logic [7:0] m, input logic [7:0] s, input bit p);
    rst = r; en = e; load = l;
    load_hh = h; load_mm = m; load_ss = s; load_pm = p;
  endtask

  typedef struct {
    bit         rs;
    bit         ld;
    logic [7:0] h, m, s;
    logic [7:0] e_hh, e_mm, e_ss;
    bit         e_err24, e_err12;
  } vec_t;

  vec_t tbl[10];
  int   cnt;

  initial begin
    // Applied with en=0 so time only moves on loads.
    tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h10, 8'h20, 8'h5A, 8'h10, 8'h20, 8'h30, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h24, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h05, 8'h07, 8'h00, 8'h05, 8'h07, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h07, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h01, 8'h60, 8'h00, 8'h00, 8'h05, 8'h07, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 8'h13, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 1'b0, 1'b1};

    drive(1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
`ifdef BCD_CLOCK_ALARM_EN
    alarm_arm = 0; alarm_hh = 8'h00; alarm_mm = 8'h01; alarm_pm = 0;
`endif

    // Reset then free-run for 40 cycles.
    cyc(); cyc();
    chk("rst_hh24", hh_a, 8'h00);
    chk("rst_hh12", hh_b, 8'h12);
    chk("rst_ss", ss_a, 8'h00);
    chk("rst_tick", tick_a, 1'b0);
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk("tick_period", tick_a, (k % 4 == 0));
      chk("ss_units_bcd", ss_a[3:0] <= 4'd9, 1'b1);
    end
    chk("ss_after_10", ss_a, 8'h10);

    // Load validation vectors.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rs, 0, tbl[i].ld, tbl[i].h, tbl[i].m, tbl[i].s, 0);
      cyc();
      chk("vec_hh", hh_a, tbl[i].e_hh);
      chk("vec_mm", mm_a, tbl[i].e_mm);
      chk("vec_ss", ss_a, tbl[i].e_ss);
      chk("vec_err24", err_a, tbl[i].e_err24);
      chk("vec_err12", err_b, tbl[i].e_err12);
    end

    // 24h midnight wrap.
    drive(0, 1, 1, 8'h23, 8'h59, 8'h58, 0);
    cyc();
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (wrap_a) cnt++;
      if (k == 4) begin
        chk("wrap24_first_ss", ss_a, 8'h59);
        chk("wrap24_first_wrap", wrap_a, 1'b0);
      end
      if (k == 8) begin
        chk("wrap24_hh", hh_a, 8'h00);
        chk("wrap24_mm", mm_a, 8'h00);
        chk("wrap24_ss", ss_a, 8'h00);
        chk("wrap24_tick", tick_a, 1'b1);
        chk("wrap24_wrap", wrap_a, 1'b1);
      end
    end
    chk("wrap24_count", cnt, 1);

    // 12h AM->PM and PM->AM.
    drive(0, 1, 1, 8'h11, 8'h59, 8'h59, 0);
    cyc();
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    repeat (4) cyc();
    chk("am_pm_hh", hh_b, 8'h12);
    chk("am_pm_ss", ss_b, 8'h00);
    chk("am_pm_pm", pm_b, 1'b1);
    chk("am_pm_wrap", wrap_b, 1'b0);
    drive(0, 1, 1, 8'h11, 8'h59, 8'h59, 1);
    cyc();
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    repeat (4) cyc();
    chk("pm_am_hh", hh_b, 8'h12);
    chk("pm_am_mm", mm_b, 8'h00);
    chk("pm_am_pm", pm_b, 1'b0);
    chk("pm_am_wrap", wrap_b, 1'b1);

    // Load on terminal count, en low on terminal count, reset mid-count.
    drive(0, 1, 1, 8'h01, 8'h02, 8'h03, 0);
    cyc();
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    repeat (3) cyc();
    drive(0, 1, 1, 8'h05, 8'h06, 8'h07, 0);
    cyc();
    chk("ldtc_hh", hh_a, 8'h05);
    chk("ldtc_ss", ss_a, 8'h07);
    chk("ldtc_tick", tick_a, 1'b0);
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("ldtc_next_tick", tick_a, (k == 4));
    end
    chk("ldtc_next_ss", ss_a, 8'h08);
    repeat (3) cyc();
    drive(0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    cyc();
    chk("entc_tick", tick_a, 1'b0);
    chk("entc_ss", ss_a, 8'h08);
    drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    cyc();
    chk("entc_resume_tick", tick_a, 1'b1);
    chk("entc_resume_ss", ss_a, 8'h09);
    repeat (2) cyc();
    drive(1, 1, 1, 8'h07, 8'h07, 8'h07, 0);
    cyc();
    chk("midrst_hh24", hh_a, 8'h00);
    chk("midrst_ss", ss_a, 8'h07 & 8'h00);
    chk("midrst_hh12", hh_b, 8'h12);
    chk("midrst_err", err_a, 1'b0);

`ifdef BCD_CLOCK_ALARM_EN
    for (int pass = 0; pass < 2; pass++) begin
      alarm_arm = (pass == 0);
      alarm_hh = 8'h00; alarm_mm = 8'h01; alarm_pm = 0;
      drive(0, 1, 1, 8'h00, 8'h00, 8'h58, 0);
      cyc();
      chk("alarm_no_load_fire", ahit_a, 1'b0);
      drive(0, 1, 0, 8'h00, 8'h00, 8'h00, 0);
      cnt = 0;
      for (int k = 1; k <= 10; k++) begin
        cyc();
        if (ahit_a) cnt++;
        if (k == 8) chk("alarm_at_0100", ahit_a, (pass == 0));
      end
      chk("alarm_count", cnt, (pass == 0) ? 1 : 0);
    end
`endif

    // Randomized run against the reference model.
    for (int k = 0; k < 4000; k++) begin
      int kind;
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 29) == 0);
      load_pm = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          load_hh = 8'($urandom); load_mm = 8'($urandom); load_ss = 8'($urandom);
        end
        1: begin
          load_hh = bcd($urandom_range(0, 23)); load_mm = bcd($urandom_range(0, 59));
          load_ss = bcd($urandom_range(0, 59));
        end
        2: begin
          load_hh = $urandom_range(0, 1) ? 8'h23 : 8'h11; load_mm = 8'h59;
          load_ss = bcd($urandom_range(50, 59));
        end
        default: begin
          load_hh = bcd($urandom_range(1, 12)); load_mm = bcd($urandom_range(55, 59));
          load_ss = bcd($urandom_range(0, 59));
        end
      endcase
`ifdef BCD_CLOCK_ALARM_EN
      if ($urandom_range(0, 49) == 0) begin
        alarm_arm = 1'($urandom_range(0, 1));
        alarm_hh = bcd($urandom_range(0, 12));
        alarm_mm = $urandom_range(0, 1) ? 8'h00 : 8'h59;
        alarm_pm = 1'($urandom_range(0, 1));
      end
`endif
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
